// File: rtl/gemm_tile_sequencer.sv
// Hardware tile loop for the GEMM accelerator: walks n/m/k tiles, programs the
// accelerator registers over the system bus and polls status between tiles.
module gemm_tile_sequencer #(
    parameter int          BLK_N     = 8,
    parameter int          BLK_K     = 16,
    parameter int          BLK_M     = 16,
    parameter int          DIM_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [31:0]      addr_a,
    input  logic [31:0]      addr_b,
    input  logic [31:0]      addr_c,
    output logic             busy,
    output logic             done,
    output logic [15:0]      tile_count,
    output logic             system_bus_en,
    output logic             system_bus_rdwr,
    output logic [31:0]      system_bus_addr,
    output logic [31:0]      system_bus_wr_data,
    input  logic [31:0]      system_bus_rd_data
);
    // one spare bit so tile offsets can step past the dimension without wrapping
    localparam int CW = DIM_W + 1;
    localparam logic [CW-1:0] BN = CW'(BLK_N);
    localparam logic [CW-1:0] BK = CW'(BLK_K);
    localparam logic [CW-1:0] BM = CW'(BLK_M);

    typedef enum logic [3:0] {
        IDLE, CFG_K, CFG_N, WR_A, WR_B, WR_C, WR_FLG, WR_SZ, POLL_RD, POLL_CHK, NEXT, FIN
    } state_t;

    state_t           state, state_nx;
    logic [DIM_W-1:0] dm, dk, dn;
    logic [31:0]      a_base, b_base, c_base;
    logic [CW-1:0]    m_q, k_q, n_q;
    logic [CW-1:0]    msize, ksize, nsize;
    logic             m_last, k_last, n_last, zero_dim;
    logic [31:0]      addr_a_t, addr_b_t, addr_c_t;
    logic             beat_en, beat_wr;
    logic [31:0]      beat_addr, beat_data;
    logic             rdwr_q;
    logic [31:0]      addr_q, data_q;
    logic             unused;

    assign zero_dim = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);

    assign msize = (CW'(dm) - m_q < BM) ? CW'(dm) - m_q : BM;
    assign ksize = (CW'(dk) - k_q < BK) ? CW'(dk) - k_q : BK;
    assign nsize = (CW'(dn) - n_q < BN) ? CW'(dn) - n_q : BN;
    assign m_last = (m_q + BM >= CW'(dm));
    assign k_last = (k_q + BK >= CW'(dk));
    assign n_last = (n_q + BN >= CW'(dn));

    // B points at the last K-row of the tile slab
    assign addr_a_t = a_base + 32'(k_q) + 32'(m_q) * 32'(dk);
    assign addr_b_t = b_base + 32'(n_q) + (32'(k_q) + 32'(ksize) - 32'd1) * 32'(dn);
    assign addr_c_t = c_base + 32'(n_q) + 32'(m_q) * 32'(dn);

    assign unused = ^{system_bus_rd_data[31:1], msize[CW-1:5], nsize[CW-1:5]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = zero_dim ? FIN : CFG_K;
            CFG_K:    state_nx = CFG_N;
            CFG_N:    state_nx = WR_A;
            WR_A:     state_nx = WR_B;
            WR_B:     state_nx = WR_C;
            WR_C:     state_nx = WR_FLG;
            WR_FLG:   state_nx = WR_SZ;
            WR_SZ:    state_nx = POLL_RD;
            POLL_RD:  state_nx = POLL_CHK;
            POLL_CHK: state_nx = system_bus_rd_data[0] ? POLL_RD : NEXT;
            NEXT:     state_nx = (k_last && m_last && n_last) ? FIN : WR_A;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        beat_en   = 1'b1;
        beat_wr   = 1'b1;
        beat_addr = BASE_ADDR;
        beat_data = '0;
        case (state)
            CFG_K:   begin beat_addr = BASE_ADDR + 32'd12; beat_data = 32'(dk); end
            CFG_N:   begin beat_addr = BASE_ADDR + 32'd16; beat_data = 32'(dn); end
            WR_A:    beat_data = addr_a_t;
            WR_B:    begin beat_addr = BASE_ADDR + 32'd4;  beat_data = addr_b_t; end
            WR_C:    begin beat_addr = BASE_ADDR + 32'd8;  beat_data = addr_c_t; end
            WR_FLG:  begin beat_addr = BASE_ADDR + 32'd20; beat_data = {30'b0, k_q == '0, k_last}; end
            WR_SZ:   begin
                beat_addr = BASE_ADDR + 32'd24;
                beat_data = {17'b0, nsize[4:0], ksize[4:0], msize[4:0]};
            end
            POLL_RD: beat_wr = 1'b0;
            default: beat_en = 1'b0;
        endcase
    end

    // bus fields hold their last beat value between beats
    assign system_bus_en      = beat_en;
    assign system_bus_rdwr    = beat_en ? beat_wr   : rdwr_q;
    assign system_bus_addr    = beat_en ? beat_addr : addr_q;
    assign system_bus_wr_data = beat_en ? beat_data : data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm <= '0; dk <= '0; dn <= '0;
            a_base <= '0; b_base <= '0; c_base <= '0;
            m_q <= '0; k_q <= '0; n_q <= '0;
            rdwr_q <= 1'b0; addr_q <= '0; data_q <= '0;
            busy <= 1'b0; done <= 1'b0; tile_count <= '0;
        end else begin
            done <= 1'b0;
            if (beat_en) begin
                rdwr_q <= beat_wr;
                addr_q <= beat_addr;
                data_q <= beat_data;
            end
            case (state)
                IDLE: if (start) begin
                    dm <= dim_m; dk <= dim_k; dn <= dim_n;
                    a_base <= addr_a; b_base <= addr_b; c_base <= addr_c;
                    m_q <= '0; k_q <= '0; n_q <= '0;
                    tile_count <= '0;
                    busy <= 1'b1;
                end
                WR_SZ: tile_count <= tile_count + 16'd1;
                NEXT: begin
                    if (k_last) begin
                        k_q <= '0;
                        if (m_last) begin
                            m_q <= '0;
                            n_q <= n_q + BN;
                        end else begin
                            m_q <= m_q + BM;
                        end
                    end else begin
                        k_q <= k_q + BK;
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: bus-side monitor plus a status
// responder, with hand-computed register write sequences per job.
module tb_gemm_tile_sequencer;
    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] dim_m, dim_k, dim_n;
    logic [31:0] addr_a, addr_b, addr_c;
    logic        busy, done;
    logic [15:0] tile_count;
    logic        en, rdwr;
    logic [31:0] addr, wr_data;
    logic [31:0] rd_data = '0;

    gemm_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .busy(busy), .done(done), .tile_count(tile_count),
        .system_bus_en(en), .system_bus_rdwr(rdwr),
        .system_bus_addr(addr), .system_bus_wr_data(wr_data),
        .system_bus_rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor + accelerator status model (owned solely by this process)
    logic [31:0] wa[$], wd[$];
    int          wc[$];
    int en_cnt = 0, rd_cnt = 0, done_cnt = 0, sz_cnt = 0, polls_left = 0;
    int long_sz = -1, long_n = 0;
    always @(negedge clk) begin
        if (en) begin
            en_cnt++;
            if (rdwr) begin
                wa.push_back(addr); wd.push_back(wr_data); wc.push_back(cyc);
                if (addr == BASE + 32'd24) begin
                    polls_left = (sz_cnt == long_sz) ? long_n : 0;
                    sz_cnt++;
                end
            end else begin
                rd_cnt++;
                rd_data = {31'b0, polls_left > 0};
                if (polls_left > 0) polls_left--;
            end
        end
        if (done) done_cnt++;
    end

    int tests = 0, fails = 0;
    int wb, rb, db, eb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        wb = wa.size(); rb = rd_cnt; db = done_cnt; eb = en_cnt;
    endtask

    task automatic launch(input int m, input int k, input int n,
                          input int a, input int b, input int c);
        @(negedge clk);
        dim_m = 16'(m); dim_k = 16'(k); dim_n = 16'(n);
        addr_a = 32'(a); addr_b = 32'(b); addr_c = 32'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk); #1;
    endtask

    function automatic logic [31:0] wr_addr(input int i); return wa[wb + i]; endfunction
    function automatic logic [31:0] wr_dat(input int i);  return wd[wb + i]; endfunction

    logic [31:0] ea[7], ed[7], tb_a[3], tb_b[3], tb_f[3], tc[6];

    initial begin
        rst = 1'b0; start = 1'b0;
        dim_m = '0; dim_k = '0; dim_n = '0;
        addr_a = '0; addr_b = '0; addr_c = '0;
        #1;
        check("rst_en", 32'(en), 0);
        check("rst_addr", addr, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tiles", 32'(tile_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // single tile, two busy polls
        snap(); long_sz = sz_cnt; long_n = 2;
        launch(5, 16, 8, 0, 80, 208);
        #1 check("t1_busy", 32'(busy), 1);
        wait_done("t1");
        ea = '{BASE+12, BASE+16, BASE, BASE+4, BASE+8, BASE+20, BASE+24};
        ed = '{16, 8, 0, 200, 208, 3, 8709};
        check("t1_nwr", 32'(wa.size() - wb), 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1_addr%0d", i), wr_addr(i), ea[i]);
            check($sformatf("t1_data%0d", i), wr_dat(i), ed[i]);
        end
        check("t1_reads", 32'(rd_cnt - rb), 3);
        check("t1_tiles", 32'(tile_count), 1);
        check("t1_pulses", 32'(done_cnt - db), 1);
        check("t1_idle", 32'(busy), 0);

        // K split, with a stray start mid-job that must be ignored
        snap(); long_sz = -1;
        launch(5, 40, 8, 0, 1000, 2000);
        repeat (6) @(negedge clk);
        dim_m = 1; dim_k = 1; dim_n = 1; addr_a = 32'hdead; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2");
        tb_a = '{0, 16, 32}; tb_b = '{1120, 1248, 1312}; tb_f = '{2, 0, 1};
        check("t2_nwr", 32'(wa.size() - wb), 17);
        for (int t = 0; t < 3; t++) begin
            check($sformatf("t2_a%0d", t), wr_dat(2 + 5*t), tb_a[t]);
            check($sformatf("t2_b%0d", t), wr_dat(3 + 5*t), tb_b[t]);
            check($sformatf("t2_c%0d", t), wr_dat(4 + 5*t), 2000);
            check($sformatf("t2_flg%0d", t), wr_dat(5 + 5*t), tb_f[t]);
            check($sformatf("t2_ksz%0d", t), (wr_dat(6 + 5*t) >> 5) & 32'd31, (t == 2) ? 8 : 16);
        end
        check("t2_tiles", 32'(tile_count), 3);

        // M/N split, n-outer ordering
        snap();
        launch(20, 16, 20, 0, 0, 0);
        wait_done("t3");
        tc = '{0, 320, 8, 328, 16, 336};
        check("t3_nwr", 32'(wa.size() - wb), 32);
        for (int t = 0; t < 6; t++)
            check($sformatf("t3_c%0d", t), wr_dat(4 + 5*t), tc[t]);
        check("t3_sz_last", wr_dat(31), 4612);
        check("t3_tiles", 32'(tile_count), 6);

        // long busy on tile 1: 10 busy polls, then tile 2 resumes immediately
        snap(); long_sz = sz_cnt; long_n = 10;
        launch(5, 32, 8, 0, 0, 0);
        wait_done("t4");
        check("t4_nwr", 32'(wa.size() - wb), 12);
        check("t4_reads", 32'(rd_cnt - rb), 12);
        check("t4_gap", 32'(wc[wb + 7] - wc[wb + 6]), 24);
        check("t4_wra_addr", wr_addr(7), BASE);
        check("t4_wra_data", wr_dat(7), 16);
        long_sz = -1;

        // reset during WR_B of tile 2
        snap();
        launch(5, 32, 8, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (wa.size() - wb >= 9) break;
        end
        check("t5_in_wrb", addr, BASE + 32'd4);
        check("t5_in_en", 32'(en), 1);
        rst = 1'b0;
        #1;
        check("t5_rst_en", 32'(en), 0);
        check("t5_rst_rdwr", 32'(rdwr), 0);
        check("t5_rst_addr", addr, 0);
        check("t5_rst_data", wr_data, 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_tiles", 32'(tile_count), 0);
        @(negedge clk);
        rst = 1'b1;
        snap();
        launch(5, 32, 8, 0, 0, 0);
        wait_done("t5");
        check("t5_first_addr", wr_addr(0), BASE + 32'd12);
        check("t5_first_data", wr_dat(0), 32);
        check("t5_nwr", 32'(wa.size() - wb), 12);
        check("t5_tiles", 32'(tile_count), 2);

        // zero dimension: done two cycles after start, no bus traffic
        snap();
        launch(5, 16, 0, 0, 0, 0);
        #1;
        check("t6_done_early", 32'(done), 0);
        check("t6_busy", 32'(busy), 1);
        @(negedge clk); #1;
        check("t6_done", 32'(done), 1);
        check("t6_busy_off", 32'(busy), 0);
        repeat (3) @(negedge clk);
        #1;
        check("t6_en", 32'(en_cnt - eb), 0);
        check("t6_pulses", 32'(done_cnt - db), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
- Hardware tiling master that sits directly upstream of the GEMM accelerator's system-bus register file; replaces the software tile loop.
- Given full-matrix dims M, K, N and base addresses of A, B and C, it walks tiles in the order n outer, m middle, k inner.
- For each tile it writes the accelerator config registers over the system bus, then polls status until the tile completes.

Parameters:
- BLK_N, 8, tile width in N (systolic super-array rows)
- BLK_K, 16, tile depth in K (systolic super-array cols)
- BLK_M, 16, tile height in M
- DIM_W, 16, width of dimension inputs
- BASE_ADDR, 32'h9000_0000, accelerator register base

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request; sampled only in IDLE
- dim_m, dim_k, dim_n  in  DIM_W each  matrix dims, latched on accepted start
- addr_a, addr_b, addr_c  in  32 each  matrix base addresses, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end
- tile_count  out  16  tiles issued in the current/last job
- system_bus_en  out  1  bus request
- system_bus_rdwr  out  1  1 = write, 0 = read
- system_bus_addr  out  32  bus address
- system_bus_wr_data  out  32  write data
- system_bus_rd_data  in  32  read data, valid one cycle after the read beat

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; latched dims and addresses cleared. Reset mid-job aborts immediately; system_bus_en drops in the same instant.
- States: IDLE, CFG_K, CFG_N, WR_A, WR_B, WR_C, WR_FLG, WR_SZ, POLL_RD, POLL_CHK, NEXT, FIN.
- Every write state drives exactly one write beat (en=1, rdwr=1) for one cycle, then advances.
- IDLE + start:
  - Any dim = 0: go to FIN with no bus traffic.
  - Otherwise: go to CFG_K; n, m, k = 0; tile_count = 0.
- CFG_K writes BASE+12 = K. CFG_N writes BASE+16 = N.
- Per tile:
  - nsize = min(BLK_N, N-n); msize = min(BLK_M, M-m); ksize = min(BLK_K, K-k).
  - WR_A: BASE+0 = A + k + m*K.
  - WR_B: BASE+4 = B + n + k*N + (ksize-1)*N.
  - WR_C: BASE+8 = C + n + m*N.
  - WR_FLG: BASE+20 = {30'b0, first, last}; first = (k==0), last = (k+BLK_K >= K).
  - WR_SZ: BASE+24 = {17'b0, nsize[4:0], ksize[4:0], msize[4:0]}. This write triggers the accelerator, which raises status in that same cycle.
  - tile_count increments on the WR_SZ beat.
- All address arithmetic is 32-bit modulo 2^32. Running-sum strides are permitted in place of multipliers, provided the results are bit-identical.
- Polling:
  - POLL_RD drives a read beat (en=1, rdwr=0, addr=BASE+0).
  - POLL_CHK deasserts en and samples rd_data[0]: 1 → POLL_RD; 0 → NEXT.
  - There is no timeout.
- NEXT: k += BLK_K. If k >= K: k = 0, m += BLK_M. If m >= M: m = 0, n += BLK_N. If n >= N: go to FIN; otherwise go to WR_A.
- FIN: done = 1 for one cycle, busy = 0, return to IDLE.
- Outside beats: system_bus_en = 0; rdwr, addr and wr_data hold their last values.
- start while busy is ignored. Input changes during a job have no effect.
- Sizes ≥ 32 are not supported; BLK_* must be ≤ 31.

Test Plan:
- Single tile. M=5, K=16, N=8, A=0, B=80, C=208; status reads 1 twice, then 0.
  - Writes in order: 16, 8, 0, 200, 208, 3, 8709.
  - Exactly 3 status reads; done pulse; tile_count=1.
- K split. M=5, K=40, N=8, A=0, B=1000, C=2000.
  - 3 tiles; A = 0, 16, 32; B = 1120, 1248, 1312; C = 2000 each.
  - Flags = 2, 0, 1; ksize fields 16, 16, 8.
- M/N split. M=20, K=16, N=20, C=0.
  - 6 tiles in n-outer order; tile_count=6.
  - Last tile: C = 336, sizes word = 4 | 16<<5 | 4<<10 = 4612.
- Long busy: status held at 1 for 10 polls after tile 1.
  - No write beat occurs until a 0 is read; then WR_A of tile 2 follows immediately.
- Reset during WR_B of tile 2: all outputs 0 asynchronously.
  - A new start reissues from CFG_K with tile_count=0.
- Zero dim: start with N=0 → done pulse 2 cycles after start; system_bus_en never asserted.
- start during busy: ignored; current job's write sequence is unchanged.
